display_scheduler: RTL and testbench

- Shares the 8-digit seven-segment display between four 32-bit requesters (e.g. PC, instruction, ALU result, debug word).
- Selects one page at a time, manually via a debounced button or by timed auto-rotation, with a freeze option.
- Generates the scan-rate enable tick that paces the display's digit-multiplex logic.
- Sits between the CPU debug taps and the display block; data_out feeds the display's 32-bit input.

---
 rtl/display_scheduler.sv | 166 ++++++++++++++++
 tb/tb_display_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Page scheduler for the shared 8-digit display: chooses one of four 32-bit
// sources (button, timed rotation or freeze) and generates the scan-rate tick.
module display_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int ROTATE_TICKS = 1000,
  parameter int DEBOUNCE     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic [3:0]  src_valid,
  input  logic        btn_next,
  input  logic        auto_mode,
  input  logic        freeze,
  output logic [31:0] data_out,
  output logic [1:0]  page,
  output logic        page_valid,
  output logic        scan_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROT_W = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_TICKS - 1);
  localparam logic [ROT_W-1:0] ROT_ONE  = ROT_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [DIV_W-1:0] div_cnt;
  logic             btn_meta;
  logic             btn_sync;
  logic             deb_level;
  logic [DEB_W-1:0] stab_cnt;
  logic             deb_flip;
  logic             btn_adv;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             leaving_frozen;
  logic [ROT_W-1:0] rot_cnt;
  logic             timeout;
  logic             active;
  logic             recover;
  logic             advance;
  logic [1:0]       page_next;
  logic [31:0]      src_sel;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= (div_cnt == DIV_LAST);
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_next;
      btn_sync <= btn_meta;
    end
  end

  // The flip happens on the sample that would bring the run length to DEBOUNCE.
  assign deb_flip = scan_tick && (btn_sync != deb_level) && (stab_cnt == DEB_LAST);
  assign btn_adv  = deb_flip && btn_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_level <= 1'b0;
      stab_cnt  <= '0;
    end else if (scan_tick) begin
      if (btn_sync == deb_level) begin
        stab_cnt <= '0;
      end else if (stab_cnt == DEB_LAST) begin
        deb_level <= btn_sync;
        stab_cnt  <= '0;
      end else begin
        stab_cnt <= stab_cnt + DEB_ONE;
      end
    end
  end

  // The datapath acts on the state being entered this clk, so freeze and
  // its release take effect on the very next edge.
  always_comb begin
    if (freeze)         state_next = ST_FROZEN;
    else if (auto_mode) state_next = ST_AUTO;
    else                state_next = ST_MANUAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_MANUAL;
    else      state <= state_next;
  end

  assign leaving_frozen = (state == ST_FROZEN) && (state_next != ST_FROZEN);
  assign active         = (state_next != ST_FROZEN);
  assign timeout        = (state_next == ST_AUTO) && scan_tick && (rot_cnt == ROT_LAST);
  assign recover        = active && !src_valid[page] && (src_valid != 4'b0000);
  assign advance        = active && (btn_adv || timeout || recover);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_cnt <= '0;
    end else if (state_next == ST_FROZEN) begin
      rot_cnt <= rot_cnt;
    end else if (state_next != ST_AUTO || advance || leaving_frozen) begin
      rot_cnt <= '0;
    end else if (scan_tick) begin
      rot_cnt <= rot_cnt + ROT_ONE;
    end
  end

  // Descending loop: the nearest valid index after cur wins; cur if none.
  function automatic logic [1:0] next_valid(input logic [1:0] cur,
                                            input logic [3:0] valid);
    logic [1:0] cand;
    next_valid = cur;
    for (int i = 3; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (valid[cand]) next_valid = cand;
    end
  endfunction

  assign page_next = next_valid(page, src_valid);

  // NOTE: every always_comb output gets a value on every path (default arm),
  // otherwise synthesis infers a latch.
  always_comb begin
    case (page)
      2'd0:    src_sel = src0;
      2'd1:    src_sel = src1;
      2'd2:    src_sel = src2;
      default: src_sel = src3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page       <= 2'd0;
      page_valid <= 1'b0;
      data_out   <= '0;
    end else if (active) begin
      if (advance) page <= page_next;
      page_valid <= src_valid[page];
      data_out   <= src_valid[page] ? src_sel : 32'h0;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: page changes are checked against
// a queue of expected pages; levels and latencies are checked inline per test.
module tb_display_scheduler;

  localparam int SCAN_DIV     = 4;
  localparam int ROTATE_TICKS = 2;
  localparam int DEBOUNCE     = 3;

  localparam logic [31:0] D0 = 32'h12345678;
  localparam logic [31:0] D1 = 32'hA5A50001;
  localparam logic [31:0] D2 = 32'hDEADBEEF;
  localparam logic [31:0] D3 = 32'h0BADF00D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] src0, src1, src2, src3;
  logic [3:0]  src_valid;
  logic        btn_next, auto_mode, freeze;
  logic [31:0] data_out;
  logic [1:0]  page;
  logic        page_valid;
  logic        scan_tick;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_page = 2'd0;
  logic [1:0] mon_exp;

  display_scheduler #(
    .SCAN_DIV(SCAN_DIV), .ROTATE_TICKS(ROTATE_TICKS), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst(rst),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .src_valid(src_valid), .btn_next(btn_next),
    .auto_mode(auto_mode), .freeze(freeze),
    .data_out(data_out), .page(page), .page_valid(page_valid),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Scoreboard: every page change must match the next expected page.
  always @(negedge clk) begin
    if (!rst) begin
      prev_page = 2'd0;
    end else if (page !== prev_page) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL page_seq: unexpected change %0d -> %0d at %0t", prev_page, page, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (page !== mon_exp) begin
          errors++;
          $display("FAIL page_seq: got page %0d expected %0d at %0t", page, mon_exp, $time);
        end
      end
      prev_page = page;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick_edge();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_tick !== 1'b1 && n < 20);
    if (scan_tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no scan_tick in 20 clks, expected one");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_page(input logic [1:0] want, input int bound);
    int n = 0;
    while (page !== want && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (page !== want) begin
      errors++;
      $display("FAIL page_wait: got page %0d expected %0d", page, want);
    end
  endtask

  task automatic test_reset();
    int last = -1;
    int n_ticks = 0;
    src0 = D0; src1 = D1; src2 = D2; src3 = D3;
    src_valid = 4'hF; btn_next = 1'b0; auto_mode = 1'b0; freeze = 1'b0;
    rst = 1'b0;
    #3;
    checks += 4;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", data_out); end
    if (page !== 2'd0)      begin errors++; $display("FAIL rst_page: got %0d expected 0", page); end
    if (page_valid !== 1'b0) begin errors++; $display("FAIL rst_pvalid: got %b expected 0", page_valid); end
    if (scan_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", scan_tick); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (data_out !== D0)     begin errors++; $display("FAIL init_data: got %h expected %h", data_out, D0); end
    if (page !== 2'd0)       begin errors++; $display("FAIL init_page: got %0d expected 0", page); end
    if (page_valid !== 1'b1) begin errors++; $display("FAIL init_pvalid: got %b expected 1", page_valid); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (scan_tick === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != SCAN_DIV) begin
            errors++;
            $display("FAIL tick_period: got %0d clks expected %0d", c - last, SCAN_DIV);
          end
        end
        last = c;
        n_ticks++;
      end
    end
    checks++;
    if (n_ticks != 5) begin errors++; $display("FAIL tick_count: got %0d expected 5", n_ticks); end
  endtask

  task automatic test_debounce();
    wait_tick_edge();
    btn_next = 1'b1;
    repeat (2) wait_tick_edge();
    btn_next = 1'b0;
    repeat (4) wait_tick_edge();
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL short_press: got page %0d expected 0", page); end
    exp_q.push_back(2'd1);
    btn_next = 1'b1;
    wait_page(2'd1, 60);
    checks++;
    if (data_out !== D0) begin errors++; $display("FAIL adv_lag: got %h expected %h", data_out, D0); end
    @(negedge clk);
    checks++;
    if (data_out !== D1) begin errors++; $display("FAIL adv_data: got %h expected %h", data_out, D1); end
    repeat (2) wait_tick_edge();
    btn_next = 1'b0;
    repeat (5) wait_tick_edge();
    checks++;
    if (page !== 2'd1) begin errors++; $display("FAIL single_adv: got page %0d expected 1", page); end
  endtask

  task automatic test_skip_invalid();
    logic [1:0] last;
    int changes = 0;
    int ticks = 0;
    src_valid = 4'b0001;
    exp_q.push_back(2'd0);
    wait_page(2'd0, 20);
    @(posedge clk);
    #1;
    auto_mode = 1'b1;
    src_valid = 4'b1001;
    exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    last = page;
    for (int c = 0; c < 100 && changes < 3; c++) begin
      @(negedge clk);
      if (page !== last) begin
        changes++;
        if (changes >= 2) begin
          checks++;
          if (ticks != ROTATE_TICKS) begin
            errors++;
            $display("FAIL hold_ticks: got %0d scan_ticks expected %0d", ticks, ROTATE_TICKS);
          end
        end
        ticks = 0;
        last = page;
      end
      if (scan_tick === 1'b1) ticks++;
    end
    checks++;
    if (changes != 3) begin errors++; $display("FAIL rotate_count: got %0d changes expected 3", changes); end
    #1 auto_mode = 1'b0;
    @(negedge clk);
    checks += 2;
    if (data_out !== D3)     begin errors++; $display("FAIL skip_data: got %h expected %h", data_out, D3); end
    if (page_valid !== 1'b1) begin errors++; $display("FAIL skip_pvalid: got %b expected 1", page_valid); end
  endtask

  task automatic test_freeze();
    int ticks = 0;
    @(posedge clk);
    #1;
    src2 = D2;
    src_valid = 4'b0100;
    exp_q.push_back(2'd2);
    wait_page(2'd2, 20);
    wait_tick_edge();
    auto_mode = 1'b1;
    wait_tick_edge();
    freeze = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== D2) begin errors++; $display("FAIL frz_entry: got %h expected %h", data_out, D2); end
    #1;
    src2 = 32'h0;
    src_valid = 4'hF;
    btn_next = 1'b1;
    repeat (5) wait_tick_edge();
    btn_next = 1'b0;
    repeat (5) wait_tick_edge();
    checks += 3;
    if (page !== 2'd2)       begin errors++; $display("FAIL frz_page: got %0d expected 2", page); end
    if (data_out !== D2)     begin errors++; $display("FAIL frz_data: got %h expected %h", data_out, D2); end
    if (page_valid !== 1'b1) begin errors++; $display("FAIL frz_pvalid: got %b expected 1", page_valid); end
    exp_q.push_back(2'd3);
    freeze = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL unfrz_data: got %h expected 0", data_out); end
    for (int c = 0; c < 60; c++) begin
      if (page !== 2'd2) break;
      if (scan_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    checks++;
    if (page !== 2'd3 || ticks != ROTATE_TICKS) begin
      errors++;
      $display("FAIL rot_restart: got page %0d after %0d ticks expected page 3 after %0d", page, ticks, ROTATE_TICKS);
    end
    #1 auto_mode = 1'b0;
  endtask

  task automatic test_invalidation();
    src2 = D2;
    src_valid = 4'b0010;
    exp_q.push_back(2'd1);
    wait_page(2'd1, 20);
    @(negedge clk);
    checks += 2;
    if (data_out !== D1)     begin errors++; $display("FAIL inv_src1: got %h expected %h", data_out, D1); end
    if (page_valid !== 1'b1) begin errors++; $display("FAIL inv_pvalid1: got %b expected 1", page_valid); end
    @(posedge clk);
    #1;
    src_valid = 4'b0100;
    exp_q.push_back(2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (page !== 2'd2) begin errors++; $display("FAIL inv_recover: got page %0d expected 2", page); end
    @(negedge clk);
    checks++;
    if (data_out !== D2) begin errors++; $display("FAIL inv_data2: got %h expected %h", data_out, D2); end
    @(posedge clk);
    #1;
    src_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (page !== 2'd2)       begin errors++; $display("FAIL empty_page: got %0d expected 2", page); end
    if (page_valid !== 1'b0) begin errors++; $display("FAIL empty_pvalid: got %b expected 0", page_valid); end
    if (data_out !== 32'h0)  begin errors++; $display("FAIL empty_data: got %h expected 0", data_out); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(posedge clk);
    #1;
    src_valid = 4'hF;
    wait_tick_edge();
    btn_next = 1'b1;
    wait_tick_edge();
    auto_mode = 1'b1;
    exp_q.push_back(2'd3);
    repeat (2) wait_tick_edge();
    checks++;
    if (page !== 2'd3) begin errors++; $display("FAIL coinc_page: got %0d expected 3", page); end
    auto_mode = 1'b0;
    btn_next = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (page !== 2'd3)   begin errors++; $display("FAIL coinc_hold: got page %0d expected 3", page); end
    if (data_out !== D3) begin errors++; $display("FAIL coinc_data: got %h expected %h", data_out, D3); end
    wait_tick_edge();
    do begin
      @(negedge clk);
      n++;
    end while (scan_tick !== 1'b1 && n < 20);
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (data_out !== 32'h0)  begin errors++; $display("FAIL arst_data: got %h expected 0", data_out); end
    if (page !== 2'd0)       begin errors++; $display("FAIL arst_page: got %0d expected 0", page); end
    if (page_valid !== 1'b0) begin errors++; $display("FAIL arst_pvalid: got %b expected 0", page_valid); end
    if (scan_tick !== 1'b0)  begin errors++; $display("FAIL arst_tick: got %b expected 0", scan_tick); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (page !== 2'd0)   begin errors++; $display("FAIL post_rst_page: got %0d expected 0", page); end
    if (data_out !== D0) begin errors++; $display("FAIL post_rst_data: got %h expected %h", data_out, D0); end
    repeat (6) wait_tick_edge();
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL post_rst_idle: got page %0d expected 0", page); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_skip_invalid();
    test_freeze();
    test_invalidation();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending pages expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
